// File: rtl/fp32_pkg.sv
// Shared fp32 constants, classification helpers and the argmax FSM state type.
package fp32_pkg;

  localparam logic [31:0] FP32_QNAN     = 32'h7FC0_0000;
  localparam logic [7:0]  FP32_EXP_ALL1 = 8'hFF;
  localparam logic [31:0] FP32_NEG_ZERO = 32'h8000_0000;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  function automatic logic fp32_is_nan(input logic [31:0] x);
    return (x[30:23] == FP32_EXP_ALL1) && (x[22:0] != 23'd0);
  endfunction

  // Maps fp32 onto an unsigned key whose integer order matches numeric order;
  // -0 is folded onto +0 first so the two zeros tie.
  function automatic logic [31:0] fp32_order_key(input logic [31:0] x);
    logic [31:0] xn;
    xn = (x == FP32_NEG_ZERO) ? 32'h0000_0000 : x;
    return xn[31] ? ~xn : (xn ^ 32'h8000_0000);
  endfunction

endpackage

// File: rtl/fp32_gt.sv
// Combinational strict greater-than on non-NaN fp32 operands.
module fp32_gt
  import fp32_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        a_gt_b
);

  assign a_gt_b = fp32_order_key(a) > fp32_order_key(b);

endmodule

// File: rtl/fp32_stream_argmax.sv
// Streams one frame of N_CLASSES fp32 values and holds the index/value of the
// largest one, plus a NaN-seen flag, until the result is accepted downstream.
module fp32_stream_argmax
  import fp32_pkg::*;
#(
  parameter int N_CLASSES = 10,
  parameter int IDX_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [31:0]      out_max,
  output logic             out_nan,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int CNT_W = $clog2(N_CLASSES + 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q;
  logic [31:0]        max_q;
  logic [IDX_W-1:0]   idx_q;
  logic               nan_q;
  logic               have_max_q;

  logic beat, in_nan, cand_gt, first, last, have_eff, take;

  assign beat     = in_valid && in_ready;
  assign in_nan   = fp32_is_nan(in_data);
  assign first    = (state_q == IDLE);
  assign last     = (count_q == CNT_W'(N_CLASSES - 1));
  // A new frame ignores whatever max the previous frame left behind.
  assign have_eff = have_max_q && !first;
  assign take     = beat && !in_nan && (!have_eff || cand_gt);

  fp32_gt u_gt (
    .a      (in_data),
    .b      (max_q),
    .a_gt_b (cand_gt)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: the default assignment first guarantees no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (beat) state_d = ACCUM;
      ACCUM:   if (beat && last) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    if (state_q == DONE) begin
      in_ready  = 1'b0;
      out_valid = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q    <= '0;
      max_q      <= '0;
      idx_q      <= '0;
      nan_q      <= 1'b0;
      have_max_q <= 1'b0;
    end else if (beat) begin
      count_q <= first ? CNT_W'(1) : count_q + CNT_W'(1);
      nan_q   <= in_nan || (nan_q && !first);
      if (take) begin
        max_q      <= in_data;
        idx_q      <= IDX_W'(count_q);
        have_max_q <= 1'b1;
      end else if (first) begin
        have_max_q <= 1'b0;
      end
      // A frame that ends without any ordered value reports the canonical NaN.
      if (last && in_nan && !have_eff) begin
        max_q <= FP32_QNAN;
        idx_q <= '0;
      end
    end else if (state_q == DONE && out_ready) begin
      count_q <= '0;
    end
  end

  assign out_idx = idx_q;
  assign out_max = max_q;
  assign out_nan = nan_q;

endmodule

// File: tb/tb_fp32_stream_argmax.sv
// Self-checking bench: directed frames plus random frames against a real-valued model.
module tb_fp32_stream_argmax;

  localparam int N     = 10;
  localparam int IDX_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [31:0]      in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [IDX_W-1:0] out_idx;
  logic [31:0]      out_max;
  logic             out_nan;
  logic             out_valid;
  logic             out_ready = 1'b0;

  int n_total = 0;
  int n_pass  = 0;
  logic [31:0] frame [N];

  fp32_stream_argmax #(.N_CLASSES(N), .IDX_W(IDX_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_idx   (out_idx),
    .out_max   (out_max),
    .out_nan   (out_nan),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic bit is_nan(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
  endfunction

  // Numeric value of a non-NaN fp32 pattern; infinities map beyond any finite float.
  function automatic real to_real(input logic [31:0] v);
    real m;
    int  e;
    e = int'(v[30:23]);
    if (e == 255)    m = 1.0e300;
    else if (e == 0) m = real'(v[22:0]) * (2.0 ** -149);
    else             m = (1.0 + real'(v[22:0]) / 8388608.0) * (2.0 ** (e - 127));
    return v[31] ? -m : m;
  endfunction

  task automatic model(output logic [IDX_W-1:0] ei, output logic [31:0] em, output logic en);
    int best = -1;
    en = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (is_nan(frame[i])) en = 1'b1;
      else if (best < 0 || to_real(frame[i]) > to_real(frame[best])) best = i;
    end
    if (best < 0) begin
      ei = '0;
      em = 32'h7FC0_0000;
    end else begin
      ei = IDX_W'(best);
      em = frame[best];
    end
  endtask

  function automatic logic [31:0] rand_val();
    logic [31:0] sp [6] = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000,
                            32'hFF80_0000, 32'h7FC0_0000, 32'h0000_0001};
    logic [31:0] sm [4] = '{32'h3F80_0000, 32'hBF80_0000, 32'h4000_0000, 32'h4080_0000};
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(4))
      0, 1: return r;
      2:    return sp[$urandom_range(5)];
      3:    return sm[$urandom_range(3)];
      default: return {r[31], 8'h00, r[22:0]};
    endcase
  endfunction

  task automatic run_frame(input string tag, input int gap_pct, input int hold, input bit hold_valid);
    logic [IDX_W-1:0] ei;
    logic [31:0]      em;
    logic             en;
    int               wait_n;
    for (int i = 0; i < N; i++) begin
      while ($urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
        step();
      end
      if (i == N - 1) check({tag, "_early_valid"}, 32'(out_valid), 32'd0);
      in_valid = 1'b1;
      in_data  = frame[i];
      wait_n   = 0;
      while (!in_ready && wait_n < 50) begin
        step();
        wait_n++;
      end
      if (wait_n >= 50) check({tag, "_in_ready_timeout"}, 32'(in_ready), 32'd1);
      step();
    end
    in_valid = hold_valid;
    in_data  = 32'h7F80_0000;
    model(ei, em, en);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_idx"},   32'(out_idx),   32'(ei));
    check({tag, "_max"},   out_max,        em);
    check({tag, "_nan"},   32'(out_nan),   32'(en));
    for (int c = 0; c < hold; c++) begin
      step();
      check({tag, "_hold_in_ready"}, 32'(in_ready),  32'd0);
      check({tag, "_hold_valid"},    32'(out_valid), 32'd1);
      check({tag, "_hold_idx"},      32'(out_idx),   32'(ei));
      check({tag, "_hold_max"},      out_max,        em);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    step();
    out_ready = 1'b0;
    check({tag, "_ack_valid"},    32'(out_valid), 32'd0);
    check({tag, "_ack_in_ready"}, 32'(in_ready),  32'd1);
  endtask

  initial begin
    step();
    step();
    rst_n = 1'b1;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_idx",   32'(out_idx),   32'd0);
    check("rst_out_max",   out_max,        32'h0);
    check("rst_out_nan",   32'(out_nan),   32'd0);

    // Stray out_ready outside DONE must not disturb anything.
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("idle_ready_noop", 32'(out_valid), 32'd0);

    frame = '{32'h3F80_0000, 32'h4040_0000, 32'h3F00_0000, 32'h4000_0000, 32'h3E80_0000,
              32'h3E00_0000, 32'h3DCC_CCCD, 32'h3E4C_CCCD, 32'h3E99_999A, 32'h3ECC_CCCD};
    run_frame("basic_bp", 0, 5, 1'b1);
    check("basic_const_max", out_max, 32'h4040_0000);

    frame = '{32'hC0E0_0000, 32'hC100_0000, 32'hC100_0000, 32'hC100_0000, 32'hC100_0000,
              32'hC100_0000, 32'hC000_0000, 32'hC100_0000, 32'hC100_0000, 32'hC100_0000};
    run_frame("negative_gaps", 40, 0, 1'b0);
    check("negative_const_idx", 32'(out_idx), 32'd6);

    frame = '{32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000,
              32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000};
    run_frame("zeros", 0, 1, 1'b0);

    frame = '{32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h4080_0000, 32'h3F80_0000,
              32'h3F80_0000, 32'h3F80_0000, 32'h4080_0000, 32'h3F80_0000, 32'h3F80_0000};
    run_frame("tie", 20, 0, 1'b0);

    frame = '{32'h3F80_0000, 32'h3F80_0000, 32'h7FC0_0000, 32'h3F80_0000, 32'h3F80_0000,
              32'h7F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000};
    run_frame("nan_inf", 0, 0, 1'b0);

    frame = '{32'h7FC0_0000, 32'h7F80_0001, 32'hFFC0_0000, 32'h7FC0_0000, 32'h7FC0_0000,
              32'h7FC0_0000, 32'h7FFF_FFFF, 32'h7FC0_0000, 32'h7FC0_0000, 32'h7FC0_0000};
    run_frame("all_nan", 0, 2, 1'b1);

    // Partial frame of +Inf discarded by reset; next frame must not see it.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h7F80_0000;
      step();
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    step();
    rst_n = 1'b1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready",  32'(in_ready),  32'd1);
    for (int i = 0; i < N; i++) frame[i] = 32'h3F80_0000;
    frame[8] = 32'h4000_0000;
    run_frame("after_reset", 10, 0, 1'b0);

    for (int f = 0; f < 15; f++) begin
      for (int i = 0; i < N; i++) frame[i] = rand_val();
      run_frame($sformatf("rand%0d", f), 30, $urandom_range(3), 1'($urandom_range(1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
